// File: rtl/cache.sv
// Direct-mapped, word-per-line cache tag/data store with combinational lookup.
// The surrounding controller sequences write-back and fill from hit, dirty_bit and cache_miss_addr.
module cache #(
  parameter int NUM_LINES = 256
) (
  input  logic        clk,
  input  logic        rst_b,
  input  logic [31:0] addr,
  input  logic [7:0]  data_in [0:3],
  input  logic        we,
  output logic [7:0]  data_out [0:3],
  output logic        hit,
  output logic        dirty_bit,
  output logic [31:0] cache_miss_addr
);

  localparam int IW = $clog2(NUM_LINES);
  localparam int TW = 30 - IW;

  logic [NUM_LINES-1:0] valid_r;
  logic [NUM_LINES-1:0] dirty_r;
  logic [TW-1:0]        tag_r  [NUM_LINES];
  logic [31:0]          data_r [NUM_LINES];

  logic [IW-1:0] index_s;
  logic [TW-1:0] tag_s;
  logic          hit_s;
  logic [31:0]   wdata_s;
  logic [31:0]   rdata_s;
  logic          unused_offset_s;

  assign index_s         = addr[2+IW-1:2];
  assign tag_s           = addr[31:2+IW];
  assign unused_offset_s = ^addr[1:0];
  assign wdata_s         = {data_in[0], data_in[1], data_in[2], data_in[3]};
  assign hit_s           = valid_r[index_s] && (tag_r[index_s] == tag_s);

  // Lookup outputs; an invalid line reads as zero regardless of stale data.
  always_comb begin
    rdata_s = 32'h0000_0000;
    if (valid_r[index_s]) begin
      rdata_s = data_r[index_s];
    end else begin
      rdata_s = 32'h0000_0000;
    end
    for (int k = 0; k < 4; k++) begin
      data_out[k] = rdata_s[31-8*k -: 8];
    end
    hit             = hit_s;
    dirty_bit       = valid_r[index_s] && dirty_r[index_s];
    cache_miss_addr = {tag_r[index_s], index_s, 2'b00};
  end

  // Data storage is not reset; valid bits hide stale contents.
  always_ff @(posedge clk) begin
    if (we && !rst_b) begin
      data_r[index_s] <= wdata_s;
    end
  end

  // Line bookkeeping: write hit marks dirty, write miss replaces the line clean.
  always_ff @(posedge clk or posedge rst_b) begin
    if (rst_b) begin
      valid_r <= '0;
      dirty_r <= '0;
      for (int i = 0; i < NUM_LINES; i++) begin
        tag_r[i] <= '0;
      end
    end else if (we) begin
      if (hit_s) begin
        dirty_r[index_s] <= 1'b1;
      end else begin
        tag_r[index_s]   <= tag_s;
        valid_r[index_s] <= 1'b1;
        dirty_r[index_s] <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_cache.sv
// Directed table-driven bench for cache, plus hand sequences for asynchronous reset behaviour.
module tb_cache;

  logic        clk;
  logic        rst_b;
  logic [31:0] addr;
  logic [7:0]  data_in [0:3];
  logic        we;
  logic [7:0]  data_out [0:3];
  logic        hit;
  logic        dirty_bit;
  logic [31:0] cache_miss_addr;

  int checks;
  int errors;

  cache #(.NUM_LINES(256)) dut (
    .clk(clk),
    .rst_b(rst_b),
    .addr(addr),
    .data_in(data_in),
    .we(we),
    .data_out(data_out),
    .hit(hit),
    .dirty_bit(dirty_bit),
    .cache_miss_addr(cache_miss_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] din;
    logic        we;
    logic        exp_hit;
    logic        exp_dirty;
    logic [31:0] exp_data;
    logic [31:0] exp_cma;
  } vec_t;

  vec_t vecs [20];

  task automatic set_din(input logic [31:0] d);
    for (int k = 0; k < 4; k++) data_in[k] = d[31-8*k -: 8];
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic eh, input logic ed,
                         input logic [31:0] edata, input logic [31:0] ecma);
    chk({tag, ".hit"}, {31'd0, hit}, {31'd0, eh});
    chk({tag, ".dirty"}, {31'd0, dirty_bit}, {31'd0, ed});
    chk({tag, ".data"}, {data_out[0], data_out[1], data_out[2], data_out[3]}, edata);
    chk({tag, ".cma"}, cache_miss_addr, ecma);
  endtask

  initial begin
    checks = 0;
    errors = 0;

    // Expected values describe the state seen before the vector's clock edge.
    vecs[0]  = '{32'h0000_0010, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0000_0000, 32'h0000_0010};
    vecs[1]  = '{32'h1234_5678, 32'h1122_3344, 1'b1, 1'b0, 1'b0, 32'h0000_0000, 32'h0000_0278};
    vecs[2]  = '{32'h1234_5678, 32'h0, 1'b0, 1'b1, 1'b0, 32'h1122_3344, 32'h1234_5678};
    vecs[3]  = '{32'h1234_567B, 32'h0, 1'b0, 1'b1, 1'b0, 32'h1122_3344, 32'h1234_5678};
    vecs[4]  = '{32'h1234_5678, 32'hAABB_CCDD, 1'b1, 1'b1, 1'b0, 32'h1122_3344, 32'h1234_5678};
    vecs[5]  = '{32'h1234_5678, 32'h0, 1'b0, 1'b1, 1'b1, 32'hAABB_CCDD, 32'h1234_5678};
    vecs[6]  = '{32'h8765_4678, 32'h0, 1'b0, 1'b0, 1'b1, 32'hAABB_CCDD, 32'h1234_5678};
    vecs[7]  = '{32'h8765_4678, 32'h0102_0304, 1'b1, 1'b0, 1'b1, 32'hAABB_CCDD, 32'h1234_5678};
    vecs[8]  = '{32'h8765_4678, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0102_0304, 32'h8765_4678};
    vecs[9]  = '{32'h1234_5678, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0102_0304, 32'h8765_4678};
    vecs[10] = '{32'h0000_0014, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0000_0000, 32'h0000_0014};
    vecs[11] = '{32'h0000_0014, 32'hDEAD_BEEF, 1'b1, 1'b0, 1'b0, 32'h0000_0000, 32'h0000_0014};
    vecs[12] = '{32'h0000_0014, 32'h0, 1'b0, 1'b1, 1'b0, 32'hDEAD_BEEF, 32'h0000_0014};
    vecs[13] = '{32'h8765_4678, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0102_0304, 32'h8765_4678};
    vecs[14] = '{32'h1234_5678, 32'h5566_7788, 1'b1, 1'b0, 1'b0, 32'h0102_0304, 32'h8765_4678};
    vecs[15] = '{32'h1234_5678, 32'hFFFF_FFFF, 1'b0, 1'b1, 1'b0, 32'h5566_7788, 32'h1234_5678};
    vecs[16] = '{32'h1234_5678, 32'h0, 1'b0, 1'b1, 1'b0, 32'h5566_7788, 32'h1234_5678};
    vecs[17] = '{32'hFFFF_FFFC, 32'h0F0E_0D0C, 1'b1, 1'b0, 1'b0, 32'h0000_0000, 32'h0000_03FC};
    vecs[18] = '{32'hFFFF_FFFD, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0F0E_0D0C, 32'hFFFF_FFFC};
    vecs[19] = '{32'h0000_0014, 32'h0, 1'b0, 1'b1, 1'b0, 32'hDEAD_BEEF, 32'h0000_0014};

    rst_b = 1'b1;
    we    = 1'b0;
    addr  = 32'h0000_0010;
    set_din(32'h0);
    #1;
    chk_all("reset", 1'b0, 1'b0, 32'h0, 32'h0000_0010);
    repeat (2) @(negedge clk);
    rst_b = 1'b0;

    foreach (vecs[i]) begin
      @(negedge clk);
      addr = vecs[i].addr;
      set_din(vecs[i].din);
      we = vecs[i].we;
      #1;
      chk_all($sformatf("vec%0d", i), vecs[i].exp_hit, vecs[i].exp_dirty,
              vecs[i].exp_data, vecs[i].exp_cma);
    end

    // Make 0x1234_5678 dirty again, then assert reset between edges.
    @(negedge clk);
    addr = 32'h1234_5678;
    set_din(32'hAABB_CCDD);
    we = 1'b1;
    @(negedge clk);
    we = 1'b0;
    #1;
    chk_all("pre_async", 1'b1, 1'b1, 32'hAABB_CCDD, 32'h1234_5678);
    #1;
    rst_b = 1'b1;
    #1;
    chk_all("async_rst", 1'b0, 1'b0, 32'h0, 32'h0000_0278);

    // A write held across an edge during reset must be dropped.
    set_din(32'h1357_9BDF);
    we = 1'b1;
    @(negedge clk);
    @(negedge clk);
    we = 1'b0;
    rst_b = 1'b0;
    #1;
    chk_all("wr_in_rst", 1'b0, 1'b0, 32'h0, 32'h0000_0278);
    addr = 32'h0000_0014;
    #1;
    chk_all("other_cleared", 1'b0, 1'b0, 32'h0, 32'h0000_0014);

    // Normal write after reset release still works.
    addr = 32'h1234_5678;
    set_din(32'h2468_ACE0);
    we = 1'b1;
    @(negedge clk);
    we = 1'b0;
    #1;
    chk_all("post_rst_fill", 1'b1, 1'b0, 32'h2468_ACE0, 32'h1234_5678);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
